// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit result FIFOs for ALU/MUL/DIV, one registered broadcast per cycle.
// Define CDB_ARB_FIXED_PRIO_EN for fixed DIV > MUL > ALU priority instead of round-robin.
module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [DATA_W-1:0] alu_value,
    input  logic [DATA_W-1:0] alu_pc,
    output logic              alu_ready,
    input  logic              mul_valid,
    input  logic [DATA_W-1:0] mul_value,
    input  logic [DATA_W-1:0] mul_pc,
    output logic              mul_ready,
    input  logic              div_valid,
    input  logic [DATA_W-1:0] div_value,
    input  logic [DATA_W-1:0] div_pc,
    output logic              div_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_value,
    output logic [DATA_W-1:0] cdb_pc,
    output logic [1:0]        cdb_src
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NSRC  = 3;

    typedef logic [DATA_W-1:0] word_t;

    word_t             in_value [NSRC];
    word_t             in_pc    [NSRC];
    logic [NSRC-1:0]   in_valid;
    logic [NSRC-1:0]   ready;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   nonempty;

    logic [PTR_W-1:0]  rd_ptr [NSRC];
    logic [PTR_W-1:0]  wr_ptr [NSRC];
    logic [CNT_W-1:0]  count  [NSRC];
    word_t             value_mem [NSRC][FIFO_DEPTH];
    word_t             pc_mem    [NSRC][FIFO_DEPTH];

    logic              grant_valid;
    logic [1:0]        grant_idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
    logic [1:0]        rr;
    logic [1:0]        cand;
`endif

    assign in_valid    = {div_valid, mul_valid, alu_valid};
    assign in_value[0] = alu_value;
    assign in_value[1] = mul_value;
    assign in_value[2] = div_value;
    assign in_pc[0]    = alu_pc;
    assign in_pc[1]    = mul_pc;
    assign in_pc[2]    = div_pc;

    assign alu_ready = ready[0];
    assign mul_ready = ready[1];
    assign div_ready = ready[2];

    // A full FIFO refuses a push even when it is popped on the same edge.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            ready[i]    = (count[i] < CNT_W'(FIFO_DEPTH)) && !flush;
            push[i]     = in_valid[i] && ready[i];
            nonempty[i] = (count[i] != '0);
            pop[i]      = grant_valid && (grant_idx == 2'(i));
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
`ifdef CDB_ARB_FIXED_PRIO_EN
        if (!flush) begin
            if (nonempty[2]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'd2;
            end else if (nonempty[1]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'd1;
            end else if (nonempty[0]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'd0;
            end
        end
`else
        cand = 2'd0;
        if (!flush) begin
            // Search starts just after the last granted source.
            for (int k = 1; k <= NSRC; k++) begin
                cand = 2'((int'(rr) + k) % NSRC);
                if (!grant_valid && nonempty[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
`endif
    end

    // NOTE: the storage arrays are deliberately not reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                value_mem[i][wr_ptr[i]] <= in_value[i];
                pc_mem[i][wr_ptr[i]]    <= in_pc[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr        <= 2'd2;
`endif
            cdb_valid <= 1'b0;
            cdb_value <= '0;
            cdb_pc    <= '0;
            cdb_src   <= 2'd0;
        end else if (flush) begin
            for (int i = 0; i < NSRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr        <= 2'd2;
`endif
            cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            cdb_valid <= grant_valid;
            // Payload holds its last value on idle cycles.
            if (grant_valid) begin
                cdb_value <= value_mem[grant_idx][rd_ptr[grant_idx]];
                cdb_pc    <= pc_mem[grant_idx][rd_ptr[grant_idx]];
                cdb_src   <= grant_idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
                rr        <= grant_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a queue-based reference model.
// Honours CDB_ARB_FIXED_PRIO_EN the same way as the design.
module tb_cdb_arbiter;

    localparam int W = 32;
    localparam int D = 4;

    typedef struct {
        logic [W-1:0] v;
        logic [W-1:0] pc;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         alu_valid = 1'b0, mul_valid = 1'b0, div_valid = 1'b0;
    logic [W-1:0] alu_value = '0, mul_value = '0, div_value = '0;
    logic [W-1:0] alu_pc = '0, mul_pc = '0, div_pc = '0;
    logic         alu_ready, mul_ready, div_ready;
    logic         cdb_valid;
    logic [W-1:0] cdb_value, cdb_pc;
    logic [1:0]   cdb_src;

    cdb_arbiter #(.DATA_W(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_value(alu_value), .alu_pc(alu_pc), .alu_ready(alu_ready),
        .mul_valid(mul_valid), .mul_value(mul_value), .mul_pc(mul_pc), .mul_ready(mul_ready),
        .div_valid(div_valid), .div_value(div_value), .div_pc(div_pc), .div_ready(div_ready),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_pc(cdb_pc), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per source plus the expected bus register.
    ent_t         q [3][$];
    int           rr = 2;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_value = '0;
    logic [W-1:0] exp_pc = '0;
    logic [1:0]   exp_src = 2'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) q[i].delete();
        rr        = 2;
        exp_valid = 1'b0;
        exp_value = '0;
        exp_pc    = '0;
        exp_src   = 2'd0;
    endtask

    task automatic check_bus();
        check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
        check("cdb_value", 64'(cdb_value), 64'(exp_value));
        check("cdb_pc",    64'(cdb_pc),    64'(exp_pc));
        check("cdb_src",   64'(cdb_src),   64'(exp_src));
    endtask

    // One clock: check the bus from the last edge, drive inputs, check readies, advance the model.
    task automatic step(input logic [2:0] v, input logic fl,
                        input logic [W-1:0] val [3], input logic [W-1:0] pc [3]);
        logic [2:0] rdy_exp;
        int         g;
        ent_t       e;
        @(negedge clk);
        check_bus();
        flush     = fl;
        alu_valid = v[0]; alu_value = val[0]; alu_pc = pc[0];
        mul_valid = v[1]; mul_value = val[1]; mul_pc = pc[1];
        div_valid = v[2]; div_value = val[2]; div_pc = pc[2];
        #1;
        for (int i = 0; i < 3; i++) rdy_exp[i] = (q[i].size() < D) && !fl;
        check("ready", 64'({div_ready, mul_ready, alu_ready}), 64'(rdy_exp));
        if (fl) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            rr        = 2;
            exp_valid = 1'b0;
        end else begin
            g = -1;
`ifdef CDB_ARB_FIXED_PRIO_EN
            for (int i = 2; i >= 0; i--) if (g < 0 && q[i].size() > 0) g = i;
`else
            for (int k = 1; k <= 3; k++) if (g < 0 && q[(rr + k) % 3].size() > 0) g = (rr + k) % 3;
`endif
            if (g >= 0) begin
                e         = q[g].pop_front();
                exp_valid = 1'b1;
                exp_value = e.v;
                exp_pc    = e.pc;
                exp_src   = g[1:0];
                rr        = g;
            end else begin
                exp_valid = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (v[i] && rdy_exp[i]) begin
                    e.v  = val[i];
                    e.pc = pc[i];
                    q[i].push_back(e);
                end
            end
        end
    endtask

    task automatic rand_step(input logic [2:0] v, input logic fl);
        logic [W-1:0] val [3];
        logic [W-1:0] pc [3];
        for (int i = 0; i < 3; i++) begin
            val[i] = $urandom;
            pc[i]  = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        end
        step(v, fl, val, pc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rand_step(3'b000, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_bus();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'({div_ready, mul_ready, alu_ready}), 64'(3'b111));

        // Collision right after reset: expect src 0, 1, 2 back to back.
        step(3'b111, 1'b0, '{32'hA, 32'hB, 32'hC}, '{32'h10, 32'h14, 32'h18});
        idle(5);

        // Single ALU push.
        step(3'b001, 1'b0, '{32'h11, 32'h0, 32'h0}, '{32'h100, 32'h0, 32'h0});
        idle(3);

        // Backpressure: every unit pushes every cycle, then drain.
        for (int i = 0; i < 14; i++) rand_step(3'b111, 1'b0);
        idle(14);

        // Flush with ALU and MUL entries pending, then a fresh ALU push.
        rand_step(3'b011, 1'b0);
        rand_step(3'b001, 1'b0);
        rand_step(3'b111, 1'b1);
        idle(1);
        rand_step(3'b001, 1'b0);
        idle(3);

        // ALU and DIV continuously valid.
        for (int i = 0; i < 12; i++) rand_step(3'b101, 1'b0);
        idle(12);

        // Async reset mid-burst, asserted between edges.
        for (int i = 0; i < 4; i++) rand_step(3'b111, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        alu_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0; flush = 1'b0;
        #1;
        model_reset();
        check_bus();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_mid_rst", 64'({div_ready, mul_ready, alu_ready}), 64'(3'b111));
        idle(4);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            rand_step(3'($urandom_range(0, 7)), ($urandom_range(0, 99) < 3));
        idle(16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
